// File: rtl/if_id_stall_ctrl_if.sv
// ---------------------------------------------------------------------------
// if_id_stall_ctrl_if
//   Bundles the stall/flush requests, the fetch-side inputs and the ID-side
//   outputs of the IF/ID pipeline register.
//   Modports:
//     slave  - the IF/ID register block (consumes requests, drives ID side)
//     master - the surrounding pipeline (drives requests and fetch side)
//   Signals:
//     stall, flush          hazard / branch-resolution requests
//     if_valid, if_instr,   fetch-stage instruction and PC+2
//     if_pc_plus2
//     pc_write_en, bubble   same-cycle control responses
//     id_instr, id_pc_plus2, id_valid   registered decode-stage contents
//     stall_err             sticky over-long-stall flag
//     stall_cnt             total stall cycles since reset
// ---------------------------------------------------------------------------
interface if_id_stall_ctrl_if #(
  parameter int OPERAND_WIDTH = 16
);
  logic                     stall;
  logic                     flush;
  logic                     if_valid;
  logic [OPERAND_WIDTH-1:0] if_instr;
  logic [OPERAND_WIDTH-1:0] if_pc_plus2;
  logic                     pc_write_en;
  logic [OPERAND_WIDTH-1:0] id_instr;
  logic [OPERAND_WIDTH-1:0] id_pc_plus2;
  logic                     id_valid;
  logic                     bubble;
  logic                     stall_err;
  logic [15:0]              stall_cnt;

  modport slave (
    input  stall, flush, if_valid, if_instr, if_pc_plus2,
    output pc_write_en, id_instr, id_pc_plus2, id_valid, bubble,
           stall_err, stall_cnt
  );

  modport master (
    output stall, flush, if_valid, if_instr, if_pc_plus2,
    input  pc_write_en, id_instr, id_pc_plus2, id_valid, bubble,
           stall_err, stall_cnt
  );
endinterface

// File: rtl/if_id_stall_ctrl.sv
// ---------------------------------------------------------------------------
// if_id_stall_ctrl
//   IF/ID pipeline register with stall/flush handling for the 5-stage
//   WISC-SP13 pipeline. A stall freezes the PC and the IF/ID latch and
//   injects a bubble into ID/EX; a flush squashes the instruction in IF/ID.
//   A watchdog raises a sticky error when a stall outlasts MAX_STALL cycles.
//
//   Ports:
//     clk    core clock, all state updates on the rising edge
//     rst_n  synchronous active-low reset
//     bus    if_id_stall_ctrl_if.slave (requests, fetch inputs, ID outputs)
//
//   Optional feature macro: IF_ID_STALL_CNT_EN
//     defined   - 16-bit saturating stall-cycle performance counter
//     undefined - stall_cnt tied to zero, no counter flops
// ---------------------------------------------------------------------------
module if_id_stall_ctrl #(
  parameter int                       OPERAND_WIDTH = 16,
  parameter logic [OPERAND_WIDTH-1:0] NOP_INSTR     = 16'h0800,
  parameter int                       MAX_STALL     = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  if_id_stall_ctrl_if.slave    bus
);

  localparam logic [2:0] CONSEC_SAT = 3'd7;
  localparam logic [2:0] STALL_LIM  = 3'(MAX_STALL);

  logic [OPERAND_WIDTH-1:0] id_instr_q;
  logic [OPERAND_WIDTH-1:0] id_pc_plus2_q;
  logic                     id_valid_q;
  logic [2:0]               consec_q;
  logic                     stall_err_q;

  // IF/ID latch: priority reset > flush > stall (hold) > normal load.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      id_instr_q    <= NOP_INSTR;
      id_pc_plus2_q <= '0;
      id_valid_q    <= 1'b0;
    end else if (bus.flush) begin
      id_instr_q    <= NOP_INSTR;
      id_pc_plus2_q <= '0;
      id_valid_q    <= 1'b0;
    end else if (!bus.stall) begin
      id_instr_q    <= bus.if_instr;
      id_pc_plus2_q <= bus.if_pc_plus2;
      id_valid_q    <= bus.if_valid;
    end
  end

  // Length of the current uninterrupted stall run; a flush ends the run
  // even if the stall request stays high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      consec_q <= '0;
    end else if (bus.flush || !bus.stall) begin
      consec_q <= '0;
    end else if (consec_q != CONSEC_SAT) begin
      consec_q <= consec_q + 3'd1;
    end
  end

  // Watchdog: a stall request arriving when the run already spans
  // MAX_STALL edges means the hazard window was exceeded. Sticky until reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_err_q <= 1'b0;
    end else if (bus.stall && (consec_q == STALL_LIM)) begin
      stall_err_q <= 1'b1;
    end
  end

`ifdef IF_ID_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  // Counts every stalled edge, flushed or not; holds at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
    end else if (bus.stall && (stall_cnt_q != 16'hFFFF)) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
`else
  assign bus.stall_cnt = 16'h0000;
`endif

  // A flush must let the PC take the branch target even during a stall.
  assign bus.pc_write_en = bus.flush | ~bus.stall;
  assign bus.bubble      = bus.stall | bus.flush | ~id_valid_q;

  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc_plus2 = id_pc_plus2_q;
  assign bus.id_valid    = id_valid_q;
  assign bus.stall_err   = stall_err_q;

endmodule
